seq_mul_ctrl: RTL and testbench
===============================

// Module: seq_mul_ctrl
// PURPOSE
//  Parametrised shift-add sequential multiplier with a start/busy/valid handshake.
//  Supports unsigned and two's-complement signed operands, selected per operation.
//  An optional early-exit mode cuts latency when the multiplier's upper bits are zero.
//  Sits beside the datapath as a low-area multicycle multiply unit.
// PARAMETERS
//  WIDTH       32  operand width in bits (>=2); product is 2*WIDTH bits
//  EARLY_EXIT  0   1: end the operation once no multiplier bits remain; 0: fixed WIDTH cycles
// PORTS
//  CLK            in   1        clock, rising edge
//  RST_N          in   1        asynchronous active-low reset
//  Start          in   1        request; sampled only while idle (Busy=0)
//  in_signed      in   1        1: operands are two's complement; 0: unsigned (sampled with Start)
//  in_a           in   WIDTH    multiplicand (sampled with Start)
//  in_b           in   WIDTH    multiplier (sampled with Start)
//  Busy           out  1        operation in progress
//  Product        out  2*WIDTH  result; holds its value until the next completion
//  Product_Valid  out  1        one-cycle pulse when Product is updated
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (RST_N). While RST_N=0:
//   state=IDLE, Busy=0, Product=0, Product_Valid=0, internal regs=0.
//   Reset mid-operation aborts the operation: no Valid pulse, Product=0.
//  FSM: IDLE -> RUN on Start=1; RUN -> IDLE after the final iteration. Start is ignored in RUN.
//  Load (edge where IDLE samples Start=1):
//   sign <= in_signed & (in_a[W-1]^in_b[W-1]).
//   mcand <= {W'b0, |in_a|}; mplier <= |in_b|, where |x| = x if unsigned or x>=0, else -x.
//   -2^(W-1) gives magnitude 2^(W-1), which fits in W unsigned bits.
//   acc <= 0; cnt <= 0; Busy <= 1.
//  Each RUN edge (one iteration):
//   if mplier[0]: acc += mcand (2W-bit add, no overflow possible).
//   mcand <<= 1; mplier >>= 1; cnt++.
//  Final iteration:
//   EARLY_EXIT=0: the iteration with cnt==WIDTH-1.
//   EARLY_EXIT=1: the first iteration where mplier[W-1:1]==0.
//   On that edge:
//    Product <= sign ? -(acc+addend) : (acc+addend), where addend = mplier[0] ? mcand : 0.
//    Product_Valid <= 1; Busy <= 0; state <= IDLE.
//  Product_Valid is 0 on all other edges.
//  Latency: Start sampled at edge 0 -> Product/Valid registered at edge L.
//   L = WIDTH when EARLY_EXIT=0.
//   L = max(1, msb_index(|in_b|)+1) when EARLY_EXIT=1; |in_b|=0 gives L=1.
//  Back-to-back: Start is accepted in the same cycle that Valid is high (state is already IDLE).
//  Zero result: a signed zero never produces negative output; -(0) = 0.
//  Most-negative case: -2^(W-1) * -2^(W-1) = 2^(2W-2), representable in 2W signed bits.
// TESTING
//  1 W=32, EE=0, unsigned, a=b=0xFFFFFFFF -> Valid at edge 32, Product=0xFFFFFFFE00000001.
//  2 W=32, signed, a=-3, b=5 -> Product=0xFFFFFFFFFFFFFFF1.
//    Same operands with in_signed=0 -> 0x4FFFFFFF1 (0xFFFFFFFD*5).
//  3 W=32, signed, a=b=0x80000000 -> Product=0x4000000000000000;
//    a=0x80000000, b=1 -> 0xFFFFFFFF80000000.
//  4 W=32, EE=1, a=7, b=5 -> Valid at edge 3, Product=35.
//    b=0 -> Valid at edge 1, Product=0.
//    Then Start held high continuously -> a new operation each L+1 cycles, one Valid pulse each.
//  5 Start pulsed again at edges 5 and 10 while Busy -> ignored; the single result is unchanged.
//    Drop RST_N at edge 12 -> Busy=0, Product=0 immediately, no Valid pulse.
//  6 W=8, EE=0, signed, a=-128, b=127 -> Valid at edge 8, Product=16'hC080.
//    Sweep all 256x256 pairs in both modes against a behavioural reference.

Source files
------------

// File: rtl/seq_mul_ctrl.sv
// Shift-add sequential multiplier with a start/busy/valid handshake.
// Signed operands are multiplied as magnitudes; the sign is applied on completion.
module seq_mul_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Start,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 Busy,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Product_Valid
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   sum;
  logic                 last;

  // Two's-complement magnitude: the most-negative value maps to 2^(W-1), which fits unsigned.
  always_comb begin
    mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (EARLY_EXIT) begin
      last = (mplier_q[WIDTH-1:1] == '0);
    end else begin
      last = (cnt_q == CW'(WIDTH - 1));
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = RUN;
          sign_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          prod_d  = sign_q ? -sum : sum;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign Busy          = (state_q == RUN);
  assign Product       = prod_q;
  assign Product_Valid = valid_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench: a 32-bit fixed-latency unit and an 8-bit early-exit unit
// checked against an arithmetic reference for product and latency.
module tb_seq_mul_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        a_start = 1'b0, a_sgn = 1'b0;
  logic [31:0] a_a = '0, a_b = '0;
  logic        a_busy, a_valid;
  logic [63:0] a_prod;

  logic        b_start = 1'b0, b_sgn = 1'b0;
  logic [7:0]  b_a = '0, b_b = '0;
  logic        b_busy, b_valid;
  logic [15:0] b_prod;

  seq_mul_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_a (
    .CLK(CLK), .RST_N(RST_N), .Start(a_start), .in_signed(a_sgn),
    .in_a(a_a), .in_b(a_b), .Busy(a_busy), .Product(a_prod), .Product_Valid(a_valid)
  );

  seq_mul_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .Start(b_start), .in_signed(b_sgn),
    .in_a(b_a), .in_b(b_b), .Busy(b_busy), .Product(b_prod), .Product_Valid(b_valid)
  );

  typedef struct {
    logic [63:0] prod;
    int unsigned start;
    int unsigned lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [63:0] last_a = '0;
  logic [15:0] last_b = '0;

  function automatic logic [63:0] ref_mul(bit sgn, logic [63:0] x, logic [63:0] y, int unsigned w);
    logic [63:0] m;
    logic [63:0] p;
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (sgn && x[w-1]) x = x - (64'd1 << w);
    if (sgn && y[w-1]) y = y - (64'd1 << w);
    p = x * y;
    return p & m;
  endfunction

  function automatic int unsigned ref_lat(bit sgn, logic [63:0] y, int unsigned w, bit ee);
    logic [63:0] mag;
    int unsigned l;
    if (!ee) return w;
    mag = (sgn && y[w-1]) ? ((64'd1 << w) - y) : y;
    l = 1;
    for (int unsigned i = 0; i < w; i++) if (mag[i]) l = i + 1;
    return l;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (a_valid) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_spurious_valid: got valid with product %h, expected none", a_prod);
        end else begin
          ea = qa.pop_front();
          check("a_product", a_prod, ea.prod);
          check("a_latency", 64'(cyc - 1 - ea.start), 64'(ea.lat));
          last_a = ea.prod;
        end
      end else begin
        check("a_hold", a_prod, last_a);
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if (b_valid) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_spurious_valid: got valid with product %h, expected none", b_prod);
        end else begin
          eb = qb.pop_front();
          check("b_product", 64'(b_prod), eb.prod);
          check("b_latency", 64'(cyc - 1 - eb.start), 64'(eb.lat));
          last_b = eb.prod[15:0];
        end
      end else begin
        check("b_hold", 64'(b_prod), 64'(last_b));
      end
    end
  end

  task automatic wait_idle_a();
    int unsigned n = 0;
    while (a_busy && n < 200) begin @(negedge CLK); n++; end
    if (a_busy) begin
      tests++; fails++;
      $display("FAIL a_idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic wait_idle_b();
    int unsigned n = 0;
    while (b_busy && n < 50) begin @(negedge CLK); n++; end
    if (b_busy) begin
      tests++; fails++;
      $display("FAIL b_idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic issue_a(bit sgn, logic [31:0] x, logic [31:0] y);
    exp_t e;
    wait_idle_a();
    a_sgn = sgn; a_a = x; a_b = y; a_start = 1'b1;
    e.prod  = ref_mul(sgn, 64'(x), 64'(y), 32);
    e.start = cyc;
    e.lat   = ref_lat(sgn, 64'(y), 32, 1'b0);
    qa.push_back(e);
  endtask

  task automatic op_a(bit sgn, logic [31:0] x, logic [31:0] y);
    issue_a(sgn, x, y);
    @(negedge CLK);
    a_start = 1'b0;
  endtask

  task automatic op_b(bit sgn, logic [7:0] x, logic [7:0] y);
    exp_t e;
    wait_idle_b();
    b_sgn = sgn; b_a = x; b_b = y; b_start = 1'b1;
    e.prod  = ref_mul(sgn, 64'(x), 64'(y), 8);
    e.start = cyc;
    e.lat   = ref_lat(sgn, 64'(y), 8, 1'b1);
    qb.push_back(e);
    @(negedge CLK);
    b_start = 1'b0;
  endtask

  // Start held high: one accepted operation every L+1 cycles.
  task automatic hold_b(bit sgn, logic [7:0] x, logic [7:0] y, int unsigned n);
    exp_t e;
    int unsigned l;
    wait_idle_b();
    b_sgn = sgn; b_a = x; b_b = y; b_start = 1'b1;
    l = ref_lat(sgn, 64'(y), 8, 1'b1);
    for (int unsigned k = 0; k < n; k++) begin
      e.prod  = ref_mul(sgn, 64'(x), 64'(y), 8);
      e.start = cyc + k * (l + 1);
      e.lat   = l;
      qb.push_back(e);
    end
    repeat (n * (l + 1)) @(negedge CLK);
    b_start = 1'b0;
  endtask

  // Stray Start pulses at edges 5 and 10 of a running op; optionally reset at edge 12.
  task automatic ignore_test(bit do_reset);
    issue_a(1'b0, $urandom, $urandom);
    for (int unsigned k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 5 || k == 10) begin
        a_start = 1'b1; a_sgn = ~a_sgn; a_a = $urandom; a_b = $urandom;
      end else begin
        a_start = 1'b0;
      end
    end
    if (do_reset) begin
      @(posedge CLK);
      #1 RST_N = 1'b0;
      #1;
      check("rst_mid_busy", 64'(a_busy), 64'd0);
      check("rst_mid_product", a_prod, 64'd0);
      check("rst_mid_valid", 64'(a_valid), 64'd0);
      qa.delete();
      last_a = '0;
      last_b = '0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_product", a_prod, 64'd0);
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_b_busy", 64'(b_busy), 64'd0);
    check("rst_b_product", 64'(b_prod), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    op_a(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_a(1'b1, 32'hFFFF_FFFD, 32'd5);
    op_a(1'b0, 32'hFFFF_FFFD, 32'd5);
    op_a(1'b1, 32'h8000_0000, 32'h8000_0000);
    op_a(1'b1, 32'h8000_0000, 32'd1);
    op_a(1'b1, 32'd0, 32'hFFFF_FFFF);
    op_a(1'b1, 32'hFFFF_FFFF, 32'd0);
    for (int i = 0; i < 30; i++) op_a(1'($urandom), $urandom, $urandom);
    ignore_test(1'b0);
    wait_idle_a();
    ignore_test(1'b1);
    op_a(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);

    op_b(1'b0, 8'd7, 8'd5);
    op_b(1'b0, 8'd7, 8'd0);
    op_b(1'b1, 8'h80, 8'd127);
    op_b(1'b1, 8'h80, 8'h80);
    op_b(1'b1, 8'd0, 8'hFF);
    op_b(1'b1, 8'hFF, 8'hFF);
    op_b(1'b0, 8'hFF, 8'hFF);
    hold_b(1'b0, 8'd7, 8'd5, 4);
    hold_b(1'b0, 8'd9, 8'd0, 4);
    hold_b(1'b1, 8'($urandom), 8'($urandom), 3);
    for (int i = 0; i < 800; i++) begin
      op_b(1'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom));
    end

    for (int n = 0; n < 100 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge CLK);
    if (qa.size() != 0 || qb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
